axis_skid_fifo: RTL

- Parametrised successor to the two-entry stream skid buffer: an AXI-Stream buffer of DEPTH entries with fully registered handshake outputs.
- Adds TLAST transport, occupancy reporting, an almost-full flag, and an optional packet (store-and-forward) mode.
- Sits between stream producers and consumers to break the ready/valid timing paths and absorb burst stalls.

---
 rtl/axis_skid_fifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/axis_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_fifo
// Brief    : AXI-Stream FIFO with flop-driven handshakes, TLAST, level,
//            almost-full flag and optional store-and-forward packet mode.
// Revision : 1.0
// ============================================================================
module axis_skid_fifo #(
    parameter int N            = 5,
    parameter int NB           = N * 8,
    parameter int DEPTH        = 4,
    parameter int PKT_MODE     = 0,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NB-1:0]              in_tdata,
    input  logic                       in_tlast,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    output logic [NB-1:0]              out_tdata,
    output logic                       out_tlast,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int RS = DEPTH - 1;
    localparam int PW = (RS > 1) ? $clog2(RS) : 1;
    localparam logic [PW-1:0] c_PTR_LAST = PW'(RS - 1);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] c_DEPTH    = LW'(DEPTH);
    localparam logic [LW-1:0] c_AFULL    = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] c_ONE      = LW'(1);

    // The output register always holds the oldest beat; the ring holds the rest.
    logic [NB:0]   r_mem [RS];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_pkt_cnt;

    logic          w_wr;
    logic          w_rd;
    logic          w_push;
    logic          w_pop;
    logic          w_load_in;
    logic          w_vld_next;
    logic [LW-1:0] w_level_next;
    logic [LW-1:0] w_pkt_next;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
    endfunction

    always_comb begin
        w_wr = in_tvalid & in_tready;
        w_rd = out_tvalid & out_tready;

        w_level_next = level;
        if (w_wr && !w_rd) begin
            w_level_next = level + c_ONE;
        end else if (!w_wr && w_rd) begin
            w_level_next = level - c_ONE;
        end

        w_pkt_next = r_pkt_cnt;
        if ((w_wr && in_tlast) && !(w_rd && out_tlast)) begin
            w_pkt_next = r_pkt_cnt + c_ONE;
        end else if (!(w_wr && in_tlast) && (w_rd && out_tlast)) begin
            w_pkt_next = r_pkt_cnt - c_ONE;
        end

        // Incoming beat goes straight to the output register when it becomes the head.
        w_load_in = w_wr && ((level == '0) || (w_rd && (level == c_ONE)));
        w_push    = w_wr && !w_load_in;
        w_pop     = w_rd && (level > c_ONE);

        if (PKT_MODE != 0) begin
            w_vld_next = (w_level_next != '0) &&
                         ((w_pkt_next != '0) || (w_level_next == c_DEPTH));
        end else begin
            w_vld_next = (w_level_next != '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            level       <= '0;
            r_pkt_cnt   <= '0;
            in_tready   <= 1'b0;
            almost_full <= 1'b0;
            out_tvalid  <= 1'b0;
            out_tlast   <= 1'b0;
            out_tdata   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            level       <= w_level_next;
            r_pkt_cnt   <= w_pkt_next;
            in_tready   <= (w_level_next < c_DEPTH);
            almost_full <= (w_level_next >= c_AFULL);
            out_tvalid  <= w_vld_next;
            if (w_pop) begin
                {out_tlast, out_tdata} <= r_mem[r_rd_ptr];
                r_rd_ptr               <= f_ptr_inc(r_rd_ptr);
            end else if (w_load_in) begin
                {out_tlast, out_tdata} <= {in_tlast, in_tdata};
            end
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_push) begin
            r_mem[r_wr_ptr] <= {in_tlast, in_tdata};
        end
    end

endmodule
`default_nettype wire
